// File: rtl/usr_seq_ctrl.sv
// Command sequencer driving a 4-bit universal shift register: load / shift right N / shift left N / snapshot.
// Latency from accept: load 3 cycles, shift N -> N+2, snapshot or zero-count shift 2; result captured with a one-cycle done pulse.
// Backpressure: cmd_ready only in IDLE, no queueing; optional USR_SEQ_ROTATE_EN adds cmd_rot for rotate-style serial feedback.
module usr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_sin,
`ifdef USR_SEQ_ROTATE_EN
  input  logic             cmd_rot,
`endif
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_pdata,
  output logic             usr_sin_r,
  output logic             usr_sin_l,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPT} state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             sin_r_q;
  logic             sin_l_q;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      sin_r_q   <= 1'b0;
      sin_l_q   <= 1'b0;
      usr_mode  <= 2'b00;
      usr_pdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            busy <= 1'b1;
            case (cmd_op)
              2'b11: begin
                state     <= LOAD;
                usr_mode  <= 2'b11;
                usr_pdata <= cmd_data;
              end
              2'b01, 2'b10: begin
                if (cmd_cnt != '0) begin
                  state     <= SHIFT;
                  remaining <= cmd_cnt;
                  usr_mode  <= cmd_op;
                  sin_r_q   <= cmd_sin & ~cmd_op[1];
                  sin_l_q   <= cmd_sin & cmd_op[1];
                end else begin
                  state <= CAPT;
                end
              end
              default: state <= CAPT;
            endcase
          end
        end
        LOAD: begin
          state     <= CAPT;
          usr_mode  <= 2'b00;
          usr_pdata <= '0;
        end
        SHIFT: begin
          remaining <= remaining - 1'b1;
          // Last shift cycle: drop the mode so CAPT sees a settled register.
          if (remaining == CNT_W'(1)) begin
            state    <= CAPT;
            usr_mode <= 2'b00;
            sin_r_q  <= 1'b0;
            sin_l_q  <= 1'b0;
          end
        end
        CAPT: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= usr_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USR_SEQ_ROTATE_EN
  logic rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rot_q <= 1'b0;
    else if (cmd_valid && cmd_ready)
      rot_q <= cmd_rot;
  end

  // Rotate: the bit falling off one end re-enters at the other in the same cycle.
  assign usr_sin_r = (rot_q && usr_mode == 2'b01) ? usr_q[0]       : sin_r_q;
  assign usr_sin_l = (rot_q && usr_mode == 2'b10) ? usr_q[WIDTH-1] : sin_l_q;
`else
  assign usr_sin_r = sin_r_q;
  assign usr_sin_l = sin_l_q;
`endif

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed bench for usr_seq_ctrl with a behavioural 4-bit USR attached to its outputs.
module tb_usr_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_sin = 1'b0;
  logic             cmd_rot = 1'b0;
  logic [WIDTH-1:0] usr_q = '0;
  logic [1:0]       usr_mode;
  logic [WIDTH-1:0] usr_pdata;
  logic             usr_sin_r;
  logic             usr_sin_l;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .cmd_sin   (cmd_sin),
`ifdef USR_SEQ_ROTATE_EN
    .cmd_rot   (cmd_rot),
`endif
    .usr_q     (usr_q),
    .usr_mode  (usr_mode),
    .usr_pdata (usr_pdata),
    .usr_sin_r (usr_sin_r),
    .usr_sin_l (usr_sin_l),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Shift register datapath: SR fills the MSB, SL fills the LSB; not reset.
  always @(posedge clk) begin
    case (usr_mode)
      2'b01:   usr_q <= {usr_sin_r, usr_q[WIDTH-1:1]};
      2'b10:   usr_q <= {usr_q[WIDTH-2:0], usr_sin_l};
      2'b11:   usr_q <= usr_pdata;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] data, input logic sin, input logic rot,
                         input logic [WIDTH-1:0] exp_res, input int exp_done, input int exp_active,
                         input logic [1:0] exp_mode, input logic [WIDTH-1:0] exp_pdata,
                         input int exp_rcnt, input int exp_lcnt);
    int w, active, rc, lc, dc, mbad;
    logic busy1, d_busy, d_rdy;
    logic [WIDTH-1:0] pd, res;
    w = 0; active = 0; rc = 0; lc = 0; dc = 0; mbad = 0;
    busy1 = 1'b0; d_busy = 1'b1; d_rdy = 1'b0; pd = '0; res = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_sin = sin; cmd_rot = rot;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_val({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (usr_mode != 2'b00) active++;
      if (usr_mode != 2'b00 && usr_mode != exp_mode) mbad++;
      if (usr_mode == 2'b11) pd = usr_pdata;
      if (usr_sin_r) rc++;
      if (usr_sin_l) lc++;
      if (done) begin
        dc = c; d_busy = busy; d_rdy = cmd_ready; res = result;
        break;
      end
    end
    check_val({tag, "_done_cycle"}, 32'(dc), 32'(exp_done));
    check_val({tag, "_active"}, 32'(active), 32'(exp_active));
    check_val({tag, "_mode_bad"}, 32'(mbad), 32'd0);
    check_val({tag, "_pdata"}, 32'(pd), 32'(exp_pdata));
    check_val({tag, "_sin_r_cyc"}, 32'(rc), 32'(exp_rcnt));
    check_val({tag, "_sin_l_cyc"}, 32'(lc), 32'(exp_lcnt));
    check_val({tag, "_busy_c1"}, 32'(busy1), 32'd1);
    check_val({tag, "_busy_done"}, 32'(d_busy), 32'd0);
    check_val({tag, "_ready_done"}, 32'(d_rdy), 32'd1);
    check_val({tag, "_result"}, 32'(res), 32'(exp_res));
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int rdy_c;
    logic d1;
    logic [WIDTH-1:0] r1;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_mode", 32'(usr_mode), 32'd0);
    check_val("rst_pdata", 32'(usr_pdata), 32'd0);
    check_val("rst_sin", 32'({usr_sin_r, usr_sin_l}), 32'd0);
    check_val("rst_busy_done", 32'({busy, done}), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_ready", 32'(cmd_ready), 32'd1);

    // tag op cnt data sin rot | res done active mode pdata rcnt lcnt
    run_cmd("load1011", 2'b11, 3'd0, 4'b1011, 1'b0, 1'b0, 4'b1011, 3, 1, 2'b11, 4'b1011, 0, 0);
    run_cmd("sr2",      2'b01, 3'd2, 4'b0000, 1'b0, 1'b0, 4'b0010, 4, 2, 2'b01, 4'b0000, 0, 0);
    run_cmd("load1011b",2'b11, 3'd5, 4'b1011, 1'b1, 1'b0, 4'b1011, 3, 1, 2'b11, 4'b1011, 0, 0);
    run_cmd("sl3fill",  2'b10, 3'd3, 4'b0000, 1'b1, 1'b0, 4'b1111, 5, 3, 2'b10, 4'b0000, 0, 3);
    run_cmd("load0101", 2'b11, 3'd0, 4'b0101, 1'b0, 1'b0, 4'b0101, 3, 1, 2'b11, 4'b0101, 0, 0);
    run_cmd("sr_cnt0",  2'b01, 3'd0, 4'b1111, 1'b1, 1'b0, 4'b0101, 2, 0, 2'b01, 4'b0000, 0, 0);
    run_cmd("snap",     2'b00, 3'd6, 4'b1111, 1'b1, 1'b0, 4'b0101, 2, 0, 2'b00, 4'b0000, 0, 0);
    run_cmd("sr7fill",  2'b01, 3'd7, 4'b0000, 1'b1, 1'b0, 4'b1111, 9, 7, 2'b01, 4'b0000, 7, 0);

    // cmd_valid held through busy; second command accepted on the done cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b0110; cmd_cnt = '0; cmd_sin = 1'b0; cmd_rot = 1'b0;
    @(posedge clk);
    #1 cmd_op = 2'b00;
    rdy_c = 0; d1 = 1'b0; r1 = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        rdy_c = c; d1 = done; r1 = result;
        break;
      end
    end
    check_val("hold_ready_cycle", 32'(rdy_c), 32'd3);
    check_val("hold_done_with_ready", 32'(d1), 32'd1);
    check_val("hold_result1", 32'(r1), 32'b0110);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check_val("b2b_busy", 32'({busy, cmd_ready, done}), 32'b100);
    @(negedge clk);
    check_val("b2b_done", 32'(done), 32'd1);
    check_val("b2b_result", 32'(result), 32'b0110);

`ifdef USR_SEQ_ROTATE_EN
    run_cmd("load1001a", 2'b11, 3'd0, 4'b1001, 1'b0, 1'b0, 4'b1001, 3, 1, 2'b11, 4'b1001, 0, 0);
    run_cmd("rot1",      2'b01, 3'd1, 4'b0000, 1'b0, 1'b1, 4'b1100, 3, 1, 2'b01, 4'b0000, 1, 0);
    run_cmd("load1001b", 2'b11, 3'd0, 4'b1001, 1'b0, 1'b0, 4'b1001, 3, 1, 2'b11, 4'b1001, 0, 0);
    run_cmd("rot7",      2'b01, 3'd7, 4'b0000, 1'b0, 1'b1, 4'b0011, 9, 7, 2'b01, 4'b0000, 3, 0);
`endif

    // Reset in the middle of a long fill-shift
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 3'd5; cmd_sin = 1'b1; cmd_rot = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 check_val("mid_shift_mode", 32'(usr_mode), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_mode", 32'(usr_mode), 32'd0);
    check_val("arst_sin", 32'({usr_sin_r, usr_sin_l}), 32'd0);
    check_val("arst_busy_done", 32'({busy, done}), 32'd0);
    check_val("arst_result", 32'(result), 32'd0);
    d1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      d1 = d1 | done;
    end
    check_val("arst_no_done", 32'(d1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("arst_rel_ready", 32'(cmd_ready), 32'd1);
    check_val("arst_rel_mode", 32'(usr_mode), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
- Command sequencer for the 4-bit reversible universal shift register (USR) datapath built from the team's reversible D flip-flop cells.
- Accepts one command at a time over a valid/ready handshake: load, shift right N, shift left N, or snapshot.
- Drives the USR mode-select, parallel-load and serial-in lines for the exact number of cycles required.
- Captures the USR output and pulses done with the result.

Parameters:
- WIDTH, 4, USR data width.
- CNT_W, 3, shift-count width; max shift per command 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 snapshot, 01 shift right, 10 shift left, 11 parallel load.
- cmd_cnt  input  CNT_W  shift count; ignored for ops 00/11.
- cmd_data  input  WIDTH  parallel load value.
- cmd_sin  input  1  serial fill bit for shifts.
- usr_q  input  WIDTH  current USR register contents.
- usr_mode  output  2  USR select: 00 hold, 01 SR, 10 SL, 11 load.
- usr_pdata  output  WIDTH  USR parallel input.
- usr_sin_r  output  1  serial input entering MSB on SR.
- usr_sin_l  output  1  serial input entering LSB on SL.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  usr_q captured at completion.

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: state IDLE, usr_mode=00, usr_pdata=0, usr_sin_r=0, usr_sin_l=0, busy=0, done=0, result=0, cmd_ready=1 once rst_n deasserts.
- All outputs are registered, except cmd_ready (=state==IDLE) and the ROTATE_EN serial path.
- States: IDLE, LOAD, SHIFT, CAPT.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready at edge T0; latch op, cnt, data, sin.
  - op 11 -> LOAD.
  - op 01/10 with cnt!=0 -> SHIFT, remaining<=cnt.
  - op 00, or shift with cnt=0 -> CAPT.
- LOAD: exactly 1 cycle. usr_mode=11, usr_pdata=latched data. Then CAPT.
- SHIFT: usr_mode=01 (SR) or 10 (SL) for exactly cnt cycles.
  - Selected serial line = latched sin; the other serial line = 0.
  - remaining decrements each cycle; at remaining==1 the next state is CAPT.
- CAPT: 1 cycle, usr_mode=00, usr_pdata=0, serial lines 0. At the exiting edge: result<=usr_q, done<=1, state<=IDLE.
- done is high exactly one cycle and coincides with cmd_ready=1; a new command may be accepted in that same cycle.
- busy=1 from the cycle after T0 through CAPT inclusive; busy=0 in the done cycle.
- Latency from T0: load -> done in cycle 3; shift N -> done in cycle N+2; snapshot or cnt=0 -> done in cycle 2.
- cmd_valid while busy: ignored, no queueing; the source must hold the command until cmd_ready.
- Reset mid-operation: immediate return to reset values; the USR is left holding whatever it last latched; no done pulse.
- usr_pdata is don't-care outside LOAD but is driven 0.

Optional Feature:
- Macro: USR_SEQ_ROTATE_EN.
- Defined: adds input port cmd_rot (1 bit), latched at accept. When latched rot=1 during SHIFT, serial lines are fed combinationally from the datapath: usr_sin_r=usr_q[0] for SR, usr_sin_l=usr_q[WIDTH-1] for SL, producing rotate. When rot=0, behaviour is as without the macro.
- Undefined: cmd_rot port absent; serial fill always from cmd_sin.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT -> all outputs 0 asynchronously, no done. Release -> cmd_ready=1, usr_mode=00.
- Load: cmd_op=11, cmd_data=1011 -> one cycle of usr_mode=11 with usr_pdata=1011; done in cycle 3; result=1011 (with USR model attached).
- Shift right: after loading 1011, cmd_op=01, cnt=2, sin=0 -> usr_mode=01 for exactly 2 cycles; result=0010, done at cycle 4.
- Shift left fill: after loading 1011, op=10, cnt=3, sin=1 -> usr_sin_l=1 for 3 cycles; result=1111.
- Boundary and handshake:
  - Shift with cnt=0 -> no shift cycles, done at cycle 2, result=unchanged usr_q.
  - cmd_valid held while busy -> not accepted until the done cycle; back-to-back accept on the done cycle works.
- Rotate (macro defined): after loading 1001, op=01, cnt=1, cmd_rot=1 -> result=1100. Repeat with cnt=7 -> result=0011.
